// File: rtl/array_19_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | array_19_ctrl_if : request/response/array-port bundle for the        |
// |                    array_19_ctrl request-side controller              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface array_19_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 60,
  parameter int LANES  = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES-1:0]  req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              mem_en;
  logic              mem_wmode;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANES-1:0]  mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // master = requester plus array macro side; slave = the controller
  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, init_done,
           mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, init_done,
           mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/array_19_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | array_19_ctrl : request-side controller for the 2048x60 masked array  |
// |   with 2-entry read response buffer; optional zero-fill after reset   |
// |   compiled in by defining ARRAY_19_CTRL_INIT_EN.                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module array_19_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 60,
  parameter int LANES  = 10
) (
  input  wire logic        clock,
  input  wire logic        reset_n,
  array_19_ctrl_if.slave   bus
);

  logic              w_run;
  logic              w_init_busy;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_fire;
  logic              w_rd_fire;
  logic              w_pop;
  logic              w_push;
  logic              w_credit;
  logic [2:0]        w_pending;

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];

`ifdef ARRAY_19_CTRL_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Leave INIT on the cycle the counter wraps from the last address to 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  assign w_run         = reset_n && (state_q == ST_RUN);
  assign w_init_busy   = reset_n && (state_q == ST_INIT);
  assign w_init_addr   = cnt_q;
  assign bus.init_done = (state_q == ST_RUN);
`else
  assign w_run         = reset_n;
  assign w_init_busy   = 1'b0;
  assign w_init_addr   = '0;
  assign bus.init_done = 1'b1;
`endif

  // Reads in flight plus buffered words, net of this cycle's pop, must leave room
  assign w_pop     = (occ_q != 2'd0) && bus.resp_ready;
  assign w_push    = inflight_q;
  assign w_pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_credit  = (w_pending < 3'd2);

  assign bus.req_ready = w_run && (bus.req_write || w_credit);
  assign w_fire        = bus.req_valid && bus.req_ready;
  assign w_rd_fire     = w_fire && !bus.req_write;

  // Array drive is held at zero while reset is asserted
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wmode = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    if (w_init_busy) begin
      bus.mem_en    = 1'b1;
      bus.mem_wmode = 1'b1;
      bus.mem_addr  = w_init_addr;
      bus.mem_wmask = '1;
    end else if (w_run) begin
      bus.mem_en    = w_fire;
      bus.mem_wmode = bus.req_write;
      bus.mem_addr  = bus.req_addr;
      bus.mem_wmask = bus.req_wmask;
      bus.mem_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    inflight_d = w_rd_fire;
    occ_d      = occ_q + {1'b0, w_push} - {1'b0, w_pop};
    wr_ptr_d   = wr_ptr_q ^ w_push;
    rd_ptr_d   = rd_ptr_q ^ w_pop;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    if (w_push) begin
      buf_d[wr_ptr_q] = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

  assign bus.resp_valid = (occ_q != 2'd0);
  assign bus.resp_data  = buf_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_array_19_ctrl.sv
`default_nettype none
// Randomised scoreboard bench for array_19_ctrl: array macro model, reference
// memory model and an independent negedge monitor.
module tb_array_19_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 60;
  localparam int LANES  = 10;
  localparam int LW     = 6;
  localparam int DEPTH  = 2048;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  array_19_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();

  array_19_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural model of the array macro (1-cycle read latency)
  logic [DATA_W-1:0] arr [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  assign bus.mem_rdata = rdata_q;

  initial begin
    rdata_q <= '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ARRAY_19_CTRL_INIT_EN
      arr[i] <= DATA_W'({$urandom, $urandom});
`else
      arr[i] <= '0;
`endif
    end
  end

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_wmode) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.mem_wmask[l]) arr[bus.mem_addr][l*LW +: LW] <= bus.mem_wdata[l*LW +: LW];
        end
      end else begin
        rdata_q <= arr[bus.mem_addr];
      end
    end
  end

  // Scoreboard and counters
  typedef struct {
    logic [DATA_W-1:0] data;
    int                avail;
  } exp_t;

  exp_t              sb [$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                cyc     = 0;
  int                rel_cnt = 0;
  int                n_vec   = 0;
  int                n_err   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, inputs are stable since posedge+1
  initial begin : monitor
    bit   run;
    bit   exp_rv;
    bit   pop;
    bit   exp_rdy;
    bit   fire;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        sb.delete();
        rel_cnt = 0;
`ifdef ARRAY_19_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        chk("rst_init_done", 64'(bus.init_done), 64'd0);
`else
        chk("rst_init_done", 64'(bus.init_done), 64'd1);
`endif
        chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data",  64'(bus.resp_data),  64'd0);
        chk("rst_mem_en",     64'(bus.mem_en),     64'd0);
        chk("rst_mem_wmode",  64'(bus.mem_wmode),  64'd0);
        chk("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
        chk("rst_mem_wmask",  64'(bus.mem_wmask),  64'd0);
        chk("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);
      end else begin
        rel_cnt++;
`ifdef ARRAY_19_CTRL_INIT_EN
        run = (rel_cnt > DEPTH);
`else
        run = 1'b1;
`endif
        chk("init_done", 64'(bus.init_done), 64'(run));
        if (!run) begin
          chk("init_mem_en",     64'(bus.mem_en),     64'd1);
          chk("init_mem_wmode",  64'(bus.mem_wmode),  64'd1);
          chk("init_mem_addr",   64'(bus.mem_addr),   64'(rel_cnt - 1));
          chk("init_mem_wmask",  64'(bus.mem_wmask),  64'h3FF);
          chk("init_mem_wdata",  64'(bus.mem_wdata),  64'd0);
          chk("init_req_ready",  64'(bus.req_ready),  64'd0);
          chk("init_resp_valid", 64'(bus.resp_valid), 64'd0);
        end else begin
          exp_rv = (sb.size() > 0) && (sb[0].avail <= cyc);
          chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
          pop     = exp_rv && bus.resp_ready;
          exp_rdy = bus.req_write ? 1'b1 : ((sb.size() - int'(pop)) < 2);
          chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
          fire = bus.req_valid && bus.req_ready;
          chk("mem_en", 64'(bus.mem_en), 64'(fire));
          if (fire) begin
            chk("mem_wmode", 64'(bus.mem_wmode), 64'(bus.req_write));
            chk("mem_addr",  64'(bus.mem_addr),  64'(bus.req_addr));
            if (bus.req_write) begin
              chk("mem_wmask", 64'(bus.mem_wmask), 64'(bus.req_wmask));
              chk("mem_wdata", 64'(bus.mem_wdata), 64'(bus.req_wdata));
            end
          end
          if (pop) begin
            e = sb.pop_front();
            chk("resp_data", 64'(bus.resp_data), 64'(e.data));
          end
          if (fire) begin
            if (bus.req_write) begin
              for (int l = 0; l < LANES; l++) begin
                if (bus.req_wmask[l]) ref_mem[bus.req_addr][l*LW +: LW] = bus.req_wdata[l*LW +: LW];
              end
            end else begin
              e.data  = ref_mem[bus.req_addr];
              e.avail = cyc + 2;
              sb.push_back(e);
              chk("sb_no_overflow", 64'(sb.size() <= 2), 64'd1);
            end
          end
        end
      end
    end
  end

  // Driver
  task automatic drive(input bit v, input bit w, input int a, input logic [LANES-1:0] m,
                       input logic [DATA_W-1:0] d, input bit rr);
    @(posedge clock);
    #1;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = ADDR_W'(a);
    bus.req_wmask  = m;
    bus.req_wdata  = d;
    bus.resp_ready = rr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
  endtask

  task automatic wait_init();
`ifdef ARRAY_19_CTRL_INIT_EN
    repeat (DEPTH + 2) @(posedge clock);
`else
    @(posedge clock);
`endif
  endtask

  logic [63:0] r64;

  initial begin : driver
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_init();

    // Last address reads back zero; masked write then readback of lane 0
    drive(1'b1, 1'b0, 'h7FF, '0, '0, 1'b1);
    drive(1'b1, 1'b1, 'h123, 10'h001, 60'hFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(1'b1, 1'b0, 'h123, '0, '0, 1'b1);
    drive(1'b1, 1'b1, 'h124, 10'h000, 60'hABC_DEF0_1234_5678, 1'b1);
    drive(1'b1, 1'b0, 'h124, '0, '0, 1'b1);
    idle(4);

    // Back-to-back reads
    for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, a, '0, '0, 1'b1);
    idle(4);

    // Backpressure: only two reads fit, writes still pass
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, i, '0, '0, 1'b0);
    drive(1'b1, 1'b1, 3, 10'h3FF, 60'h123_4567_89AB_CDEF, 1'b0);
    drive(1'b1, 1'b0, 3, '0, '0, 1'b0);
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    drive(1'b0, 1'b0, 0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 3 + i, '0, '0, 1'b1);
    idle(4);

    // Reset with a read in flight
    drive(1'b1, 1'b0, 5, '0, '0, 1'b1);
    @(posedge clock);
    #1;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    wait_init();

    // Random traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom, $urandom};
      drive(($urandom_range(3) != 0), ($urandom_range(2) == 0), int'($urandom_range(15)),
            LANES'($urandom), r64[DATA_W-1:0], ($urandom_range(3) != 0));
    end
    idle(6);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/array_19_ctrl.md
# array_19_ctrl

Request-side controller for the 2048 x 60-bit single-port masked array macro (`array_19_ext`, 10 lanes of 6 bits, 1-cycle read latency). It sits directly upstream of the array:
- converts a valid/ready request channel into array port cycles;
- captures read data into a 2-entry response buffer with valid/ready backpressure;
- optionally zero-initialises the whole array after reset.

## Interface
Parameters:
- `ADDR_W`, 11, array address width (depth = 2^ADDR_W = 2048).
- `DATA_W`, 60, word width.
- `LANES`, 10, write-mask lanes. Lane width = `DATA_W`/`LANES` = 6.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_write`  in  1  1 = masked write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wmask`  in  LANES  per-lane write enable; ignored for reads.
- `req_wdata`  in  DATA_W  write data.
- `resp_valid`  out  1  read data available.
- `resp_ready`  in  1  consumer takes `resp_data`.
- `resp_data`  out  DATA_W  oldest buffered read word.
- `init_done`  out  1  controller in RUN.
- `mem_en`, `mem_wmode`, `mem_addr`, `mem_wmask`, `mem_wdata`  out  1/1/ADDR_W/LANES/DATA_W  array port drive.
- `mem_rdata`  in  DATA_W  array read data, valid the cycle after a read enable.

## Operation
FSM states: INIT (only when the macro is defined) and RUN.

INIT:
- An ADDR_W-bit counter starts at 0.
- Each cycle it drives `mem_en`=1, `mem_wmode`=1, `mem_wmask`=all ones, `mem_wdata`=0, `mem_addr`=counter, then increments.
- When the counter wraps from 2047 to 0, the FSM moves to RUN.
- `req_ready`=0 throughout INIT.

RUN:
- `fire` = `req_valid` && `req_ready`.
- Array drive:
  - `mem_en` = `fire`.
  - `mem_wmode` = `req_write`.
  - `mem_addr`, `mem_wmask`, `mem_wdata` pass through from the request.
- Response credit:
  - `pop` = `resp_valid` && `resp_ready`.
  - `credit` = (`occ` + `inflight` − `pop`) < 2, where `occ` is buffer occupancy (0..2) and `inflight` is a 1-bit register set by an accepted read.
- `req_ready` = RUN && (`req_write` || `credit`). Writes are never blocked by the response buffer.
- Response capture:
  - When `inflight`=1, `mem_rdata` is pushed into the buffer at the end of that cycle.
  - The buffer is a 2-entry FIFO and preserves read order.
  - `resp_valid` = (`occ` != 0); `resp_data` = head entry.
- A write with all-zero mask still issues an array cycle and changes no data.
- Push and pop in the same cycle: `occ` is unchanged and order is preserved.
- The credit rule guarantees no push occurs when `occ`=2 without a pop. A push into a full buffer is impossible by construction; the bench asserts it never happens.

Reset (`reset_n` low, any time, including mid-INIT or with reads in flight):
- State returns to INIT (or RUN without the macro).
- Counter, `occ` and `inflight` are cleared.
- In-flight and buffered reads are discarded.
- All array drive outputs read 0.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `mem_en`=0, `mem_wmode`=0.
  - With macro: `init_done`=0.
  - Without macro: `init_done`=1, and `req_ready` rises in the first cycle after reset release.
- Read latency: request accepted in cycle T, data captured at end of T+1, `resp_valid`=1 in T+2.
- Throughput: one read per cycle sustained when `resp_ready` is held high.
- `req_ready` depends combinationally on `req_write` and `resp_ready`. Upstream must not make `req_valid` depend on `req_ready`.
- Write accepted in T updates the array at the end of T. A read accepted in T+1 to the same address returns the new data.
- INIT duration: exactly 2048 cycles after reset release. `init_done` rises in cycle 2049.

## Configuration
- `ARRAY_19_CTRL_INIT_EN` defined:
  - INIT state and counter are compiled in.
  - The array is zero-filled after every reset before requests are accepted.
- Not defined:
  - No INIT logic.
  - FSM resets directly to RUN and `init_done` is tied to 1.
  - Array contents after reset are whatever the macro holds.

## Test plan
- Macro defined, release reset, hold `req_valid`=0 → `mem_en`=1 with `mem_wmask`=0x3FF for exactly 2048 cycles on addresses 0..2047; `init_done` rises; a read of addr 0x7FF then returns 0.
- Write addr 0x123 with data 0xFFF_FFFF_FFFF_FFFF and mask 0x001, then read 0x123 → `resp_data`=0x03F two cycles after the read is accepted (lane 0 only, rest zero after init).
- Back-to-back reads of addrs 0..15 with `resp_ready`=1 → 16 responses on consecutive cycles in order, `req_ready` never drops.
- `resp_ready`=0 and reads offered every cycle → exactly 2 reads accepted, `req_ready`=0 for reads. A write offered meanwhile is accepted. Raising `resp_ready` drains both responses in order, then reads resume.
- Accept a read, assert `reset_n`=0 on the next cycle → `resp_valid` stays 0 after release and no stale data appears. With the macro, INIT restarts from address 0.
- Simultaneous push and pop with `occ`=1 over 100 random cycles → response order matches request order and no overflow assertion fires.
